// File: rtl/la_qual_pkg.sv
// Shared encodings for the logic-analyzer sample qualifier: mode codes,
// FSM states and a width helper for the change-mode gap counter.
package la_qual_pkg;

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_CHG  = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < (max_val + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/la_probe_sync.sv
// DATA_W x SYNC_STAGES probe synchronizer. With LA_QUAL_DEGLITCH_EN defined,
// a bit only updates once it has been stable for two consecutive cycles.
module la_probe_sync #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_probe,
  output logic [DATA_W-1:0] o_filt
);

  logic [DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [DATA_W-1:0] w_s;

  // NOTE: these are discrete flops, not a RAM, so the whole array is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_probe;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef LA_QUAL_DEGLITCH_EN
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_f;
  logic [DATA_W-1:0] w_f;

  // Bits where s disagrees with its previous value keep the last filtered bit.
  assign w_f = (w_s & ~(w_s ^ r_d)) | (r_f & (w_s ^ r_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d <= '0;
      r_f <= '0;
    end else begin
      r_d <= w_s;
      r_f <= w_f;
    end
  end

  assign o_filt = w_f;
`else
  assign o_filt = w_s;
`endif

endmodule

// File: rtl/la_sample_qualifier.sv
// Probe front end for the logic-analyzer core: synchronize, decimate, and
// qualify samples (every tick / change-only / hold). LA_QUAL_DEGLITCH_EN adds a deglitch stage.
module la_sample_qualifier
  import la_qual_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16,
  parameter int MAX_GAP     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] probe_in,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div_val,
  output logic [DATA_W-1:0] data_out,
  output logic              cqual_out,
  output logic              running
);

`ifdef LA_QUAL_DEGLITCH_EN
  localparam int SETTLE_LOAD = SYNC_STAGES + 1;
`else
  localparam int SETTLE_LOAD = SYNC_STAGES;
`endif
  localparam int SET_W = $clog2(SETTLE_LOAD + 1);
  localparam int GAP_W = width_for(MAX_GAP);

  state_t            r_state, w_state_nxt;
  logic [SET_W-1:0]  r_settle, w_settle_nxt;
  logic [DIV_W-1:0]  r_count, w_count_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [DATA_W-1:0] r_prev, w_prev_nxt;
  logic              r_first, w_first_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_cqual, w_cqual_nxt;
  logic [1:0]        r_mode_q;
  logic [DATA_W-1:0] w_filt;
  logic              w_first_eff;
  logic              w_tick;

  la_probe_sync #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_probe (probe_in),
    .o_filt  (w_filt)
  );

  // Entering change-only mode forces a fresh baseline sample.
  assign w_first_eff = r_first | ((mode == MODE_CHG) && (r_mode_q != MODE_CHG));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_count_nxt  = r_count;
    w_gap_nxt    = r_gap;
    w_prev_nxt   = r_prev;
    w_first_nxt  = r_first;
    w_data_nxt   = r_data;
    w_cqual_nxt  = 1'b0;
    w_tick       = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = SET_W'(SETTLE_LOAD);
        end
      end
      SETTLE: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (r_settle <= SET_W'(1)) begin
          w_state_nxt  = RUN;
          w_settle_nxt = '0;
          w_count_nxt  = '0;
          w_gap_nxt    = '0;
          w_first_nxt  = 1'b1;
        end else begin
          w_settle_nxt = r_settle - SET_W'(1);
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_first_nxt = w_first_eff;
          w_tick      = (r_count >= div_val);
          w_count_nxt = w_tick ? '0 : r_count + DIV_W'(1);
          if (w_tick) begin
            case (mode)
              MODE_CHG: begin
                if (w_first_eff || (w_filt != r_prev) || (r_gap == GAP_W'(MAX_GAP - 1))) begin
                  w_data_nxt  = w_filt;
                  w_prev_nxt  = w_filt;
                  w_gap_nxt   = '0;
                  w_first_nxt = 1'b0;
                  w_cqual_nxt = 1'b1;
                end else begin
                  w_gap_nxt = r_gap + GAP_W'(1);
                end
              end
              MODE_HOLD: ;
              default: begin
                w_data_nxt  = w_filt;
                w_cqual_nxt = 1'b1;
              end
            endcase
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_count  <= '0;
      r_gap    <= '0;
      r_prev   <= '0;
      r_first  <= 1'b1;
      r_data   <= '0;
      r_cqual  <= 1'b0;
      r_mode_q <= MODE_ALL;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_count  <= w_count_nxt;
      r_gap    <= w_gap_nxt;
      r_prev   <= w_prev_nxt;
      r_first  <= w_first_nxt;
      r_data   <= w_data_nxt;
      r_cqual  <= w_cqual_nxt;
      r_mode_q <= mode;
    end
  end

  assign data_out  = r_data;
  assign cqual_out = r_cqual;
  assign running   = (r_state == RUN);

endmodule

// File: tb/tb_la_sample_qualifier.sv
// Self-checking bench for la_sample_qualifier: a cycle-level reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_la_sample_qualifier;
  import la_qual_pkg::*;

  localparam int DATA_W  = 16;
  localparam int SYNC    = 2;
  localparam int DIV_W   = 16;
  localparam int MAX_GAP = 4;
`ifdef LA_QUAL_DEGLITCH_EN
  localparam int LAT = SYNC + 1;
`else
  localparam int LAT = SYNC;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] probe_in;
  logic              enable;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div_val;
  logic [DATA_W-1:0] data_out;
  logic              cqual_out;
  logic              running;

  la_sample_qualifier #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .DIV_W       (DIV_W),
    .MAX_GAP     (MAX_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .probe_in  (probe_in),
    .enable    (enable),
    .mode      (mode),
    .div_val   (div_val),
    .data_out  (data_out),
    .cqual_out (cqual_out),
    .running   (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: probe history, enable streak, ticks since last tick,
  // ticks since last qualified sample, and a "need baseline" flag.
  logic [DATA_W-1:0] m_hist [SYNC];
  logic [DATA_W-1:0] m_s_last, m_f, m_last_q, m_s_use, m_f_use;
  logic [1:0]        m_mode_last;
  int                m_streak, m_since_tick, m_gap;
  bit                m_baseline, m_was_run;
  logic [DATA_W-1:0] exp_data    = '0;
  logic              exp_cqual   = 1'b0;
  logic              exp_running = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
      m_s_last = '0; m_f = '0; m_last_q = '0; m_mode_last = MODE_ALL;
      m_streak = 0; m_since_tick = 0; m_gap = 0; m_baseline = 1'b1;
      exp_data = '0; exp_cqual = 1'b0; exp_running = 1'b0;
    end else begin
      // value the design sees this edge: the probe sampled LAT edges earlier
      m_s_use = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = probe_in;
`ifdef LA_QUAL_DEGLITCH_EN
      for (int b = 0; b < DATA_W; b++)
        m_f_use[b] = (m_s_use[b] == m_s_last[b]) ? m_s_use[b] : m_f[b];
      m_f = m_f_use;
      m_s_last = m_s_use;
`else
      m_f_use = m_s_use;
`endif
      if (mode == MODE_CHG && m_mode_last != MODE_CHG) m_baseline = 1'b1;
      m_mode_last = mode;

      m_was_run = (m_streak >= LAT + 1);
      if (!enable) m_streak = 0;
      else if (m_streak < LAT + 1) m_streak++;
      exp_running = (m_streak >= LAT + 1);
      exp_cqual = 1'b0;

      if (m_was_run && enable) begin
        if (m_since_tick >= int'(div_val)) begin
          m_since_tick = 0;
          if (mode == MODE_CHG) begin
            if (m_baseline || m_f_use != m_last_q || m_gap + 1 == MAX_GAP) begin
              exp_data = m_f_use; exp_cqual = 1'b1;
              m_last_q = m_f_use; m_gap = 0; m_baseline = 1'b0;
            end else begin
              m_gap++;
            end
          end else if (mode != MODE_HOLD) begin
            exp_data = m_f_use; exp_cqual = 1'b1;
          end
        end else begin
          m_since_tick++;
        end
      end else begin
        m_since_tick = 0; m_gap = 0; m_baseline = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_data_out", 32'(data_out), 32'(exp_data));
    check("model_cqual_out", 32'(cqual_out), 32'(exp_cqual));
    check("model_running", 32'(running), 32'(exp_running));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; enable = 1'b0; mode = MODE_ALL; div_val = '0; probe_in = '0;
    step(3);
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_cqual", 32'(cqual_out), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    rst = 1'b0;
    step(1);

    // every-tick mode, divide by 4
    probe_in = 16'h1234; div_val = 16'd3; enable = 1'b1;
    step(LAT);
    check("settle_not_running", 32'(running), 32'h0);
    step(1);
    check("running_rises", 32'(running), 32'h1);
    step(4);
    check("div4_first_tick", 32'(cqual_out), 32'h1);
    check("div4_data", 32'(data_out), 32'h1234);
    step(1);
    check("div4_pulse_width", 32'(cqual_out), 32'h0);
    step(3);
    check("div4_second_tick", 32'(cqual_out), 32'h1);

    // asynchronous reset while running
    probe_in = 16'h00AA; div_val = 16'd0;
    step(LAT + 2);
    check("pre_reset_data", 32'(data_out), 32'h00AA);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", 32'(data_out), 32'h0);
    check("async_rst_cqual", 32'(cqual_out), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    enable = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // change-only mode, MAX_GAP=4
    mode = MODE_CHG; div_val = 16'd0; probe_in = 16'h0005; enable = 1'b1;
    step(LAT + 1);
    step(1);
    check("chg_baseline", 32'(cqual_out), 32'h1);
    check("chg_baseline_data", 32'(data_out), 32'h0005);
    step(1);
    check("chg_no_change", 32'(cqual_out), 32'h0);
    step(2);
    check("chg_gap3", 32'(cqual_out), 32'h0);
    probe_in = 16'h0006;
    step(1);
    check("chg_keepalive", 32'(cqual_out), 32'h1);
    check("chg_keepalive_data", 32'(data_out), 32'h0005);
    step(LAT - 1);
    check("chg_before_change", 32'(cqual_out), 32'h0);
    step(1);
    check("chg_change", 32'(cqual_out), 32'h1);
    check("chg_change_data", 32'(data_out), 32'h0006);
    step(3);
    check("chg_gap_restart", 32'(cqual_out), 32'h0);
    step(1);
    check("chg_keepalive2", 32'(cqual_out), 32'h1);

    // hold mode, then back to change-only
    mode = MODE_HOLD; probe_in = 16'h0077;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1);
      check("hold_no_qual", 32'(cqual_out), 32'h0);
    end
    check("hold_data", 32'(data_out), 32'h0006);
    probe_in = 16'h0006;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_no_qual2", 32'(cqual_out), 32'h0);
    end
    mode = MODE_CHG;
    step(1);
    check("rechg_baseline", 32'(cqual_out), 32'h1);
    check("rechg_data", 32'(data_out), 32'h0006);
    step(1);
    check("rechg_then_quiet", 32'(cqual_out), 32'h0);

    // divisor lowered below the running count
    mode = MODE_ALL; div_val = 16'd10;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (cqual_out === 1'b1) found = 1'b1;
    end
    check("div10_tick_seen", 32'(found), 32'h1);
    step(7);
    check("count7_no_tick", 32'(cqual_out), 32'h0);
    div_val = 16'd2;
    step(1);
    check("lowered_div_tick", 32'(cqual_out), 32'h1);
    step(2);
    check("div3_gap", 32'(cqual_out), 32'h0);
    step(1);
    check("div3_tick", 32'(cqual_out), 32'h1);

    // enable falls on a tick cycle: no qualify
    step(2);
    enable = 1'b0;
    step(1);
    check("disable_on_tick_cqual", 32'(cqual_out), 32'h0);
    check("disable_running", 32'(running), 32'h0);

`ifdef LA_QUAL_DEGLITCH_EN
    mode = MODE_ALL; div_val = 16'd0; probe_in = 16'h0000; enable = 1'b1;
    step(LAT + 3);
    probe_in = 16'h0001;
    step(1);
    probe_in = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_rejected", 32'(data_out[0]), 32'h0);
    end
    probe_in = 16'h0001;
    step(2);
    probe_in = 16'h0000;
    step(1);
    check("pulse2_not_yet", 32'(data_out[0]), 32'h0);
    step(1);
    check("pulse2_passed", 32'(data_out[0]), 32'h1);
    enable = 1'b0;
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
